// File: rtl/procyon_mhq_lu_mp.sv
// procyon_mhq_lu_mp: multi-port MHQ lookup stage; merges, allocates or retries each LSU lookup.
// Optional feature macro: PCYN_MHQ_LU_COALESCE_EN (merge same-cycle same-line misses into the lower port's new entry).
module procyon_mhq_lu_mp #(
    parameter int OPTN_DATA_WIDTH     = 32,
    parameter int OPTN_ADDR_WIDTH     = 32,
    parameter int OPTN_MHQ_DEPTH      = 8,
    parameter int OPTN_DC_LINE_SIZE   = 32,
    parameter int OPTN_MHQ_LU_PORTS   = 2,
    parameter int PCYN_LSU_FUNC_WIDTH = 4,
    localparam int LU_PORTS        = OPTN_MHQ_LU_PORTS,
    localparam int MHQ_IDX_WIDTH   = $clog2(OPTN_MHQ_DEPTH),
    localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE),
    localparam int WORD_SIZE       = OPTN_DATA_WIDTH / 8,
    localparam int LA_WIDTH        = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH,
    localparam int CNT_WIDTH       = $clog2(OPTN_MHQ_LU_PORTS + 1)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [MHQ_IDX_WIDTH:0]         i_mhq_tail_next,
    input  logic [MHQ_IDX_WIDTH:0]         i_mhq_head_next,
    input  logic                           i_mhq_entry_valid     [OPTN_MHQ_DEPTH],
    input  logic [LA_WIDTH-1:0]            i_mhq_entry_addr      [OPTN_MHQ_DEPTH],
    input  logic                           i_mhq_ex_bypass_en    [LU_PORTS],
    input  logic                           i_mhq_ex_bypass_we    [LU_PORTS],
    input  logic                           i_mhq_ex_bypass_match [LU_PORTS],
    input  logic [LA_WIDTH-1:0]            i_mhq_ex_bypass_addr  [LU_PORTS],
    input  logic [MHQ_IDX_WIDTH-1:0]       i_mhq_ex_bypass_tag   [LU_PORTS],
    input  logic                           i_mhq_lookup_valid    [LU_PORTS],
    input  logic                           i_mhq_lookup_dc_hit   [LU_PORTS],
    input  logic                           i_mhq_lookup_we       [LU_PORTS],
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_mhq_lookup_addr     [LU_PORTS],
    input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_mhq_lookup_lsu_func [LU_PORTS],
    input  logic [OPTN_DATA_WIDTH-1:0]     i_mhq_lookup_data     [LU_PORTS],
    input  logic                           i_ccu_done,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_ccu_addr,
    output logic                           o_mhq_lu_en           [LU_PORTS],
    output logic                           o_mhq_lu_we           [LU_PORTS],
    output logic                           o_mhq_lu_match        [LU_PORTS],
    output logic                           o_mhq_lu_retry        [LU_PORTS],
    output logic [DC_OFFSET_WIDTH-1:0]     o_mhq_lu_offset       [LU_PORTS],
    output logic [OPTN_DATA_WIDTH-1:0]     o_mhq_lu_wr_data      [LU_PORTS],
    output logic [WORD_SIZE-1:0]           o_mhq_lu_byte_select  [LU_PORTS],
    output logic [MHQ_IDX_WIDTH-1:0]       o_mhq_lu_tag          [LU_PORTS],
    output logic [LA_WIDTH-1:0]            o_mhq_lu_addr         [LU_PORTS],
    output logic [CNT_WIDTH-1:0]           o_mhq_lu_alloc_cnt
);

    localparam int BS_SHIFT_WIDTH = $clog2(WORD_SIZE);

    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_SB   = PCYN_LSU_FUNC_WIDTH'(5);
    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_SH   = PCYN_LSU_FUNC_WIDTH'(6);
    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_SW   = PCYN_LSU_FUNC_WIDTH'(7);
    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_FILL = PCYN_LSU_FUNC_WIDTH'(8);

    logic [LA_WIDTH-1:0]        lu_line   [LU_PORTS];
    logic                       lu_fill   [LU_PORTS];
    logic                       ex_hit    [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   ex_tag    [LU_PORTS];
    logic                       q_hit     [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   q_tag     [LU_PORTS];
    logic [WORD_SIZE-1:0]       bs_mask   [LU_PORTS];
    logic                       port_hit  [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   port_tag  [LU_PORTS];
    logic                       merge_hit [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   merge_tag [LU_PORTS];
    logic                       conflict  [LU_PORTS];
    logic                       alloc     [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   alloc_tag [LU_PORTS];
    logic [MHQ_IDX_WIDTH:0]     occ;
    logic [MHQ_IDX_WIDTH:0]     free;
    logic [CNT_WIDTH-1:0]       alloc_k;

    logic                       lu_en_d          [LU_PORTS];
    logic                       lu_we_d          [LU_PORTS];
    logic                       lu_match_d       [LU_PORTS];
    logic                       lu_retry_d       [LU_PORTS];
    logic [DC_OFFSET_WIDTH-1:0] lu_offset_d      [LU_PORTS];
    logic [OPTN_DATA_WIDTH-1:0] lu_wr_data_d     [LU_PORTS];
    logic [WORD_SIZE-1:0]       lu_byte_select_d [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   lu_tag_d         [LU_PORTS];
    logic [LA_WIDTH-1:0]        lu_addr_d        [LU_PORTS];
    logic [CNT_WIDTH-1:0]       alloc_cnt_d;

    logic                       lu_en_q          [LU_PORTS];
    logic                       lu_we_q          [LU_PORTS];
    logic                       lu_match_q       [LU_PORTS];
    logic                       lu_retry_q       [LU_PORTS];
    logic [DC_OFFSET_WIDTH-1:0] lu_offset_q      [LU_PORTS];
    logic [OPTN_DATA_WIDTH-1:0] lu_wr_data_q     [LU_PORTS];
    logic [WORD_SIZE-1:0]       lu_byte_select_q [LU_PORTS];
    logic [MHQ_IDX_WIDTH-1:0]   lu_tag_q         [LU_PORTS];
    logic [LA_WIDTH-1:0]        lu_addr_q        [LU_PORTS];
    logic [CNT_WIDTH-1:0]       alloc_cnt_q;

    always_comb begin
        occ  = i_mhq_tail_next - i_mhq_head_next;
        free = (MHQ_IDX_WIDTH+1)'(OPTN_MHQ_DEPTH) - occ;
    end

    // Per-port lookups that do not depend on other ports' decisions
    always_comb begin
        for (int p = 0; p < LU_PORTS; p++) begin
            lu_line[p]      = i_mhq_lookup_addr[p][OPTN_ADDR_WIDTH-1:DC_OFFSET_WIDTH];
            lu_fill[p]      = (i_mhq_lookup_lsu_func[p] == LSU_FUNC_FILL);
            lu_we_d[p]      = i_mhq_lookup_we[p];
            lu_offset_d[p]  = i_mhq_lookup_addr[p][DC_OFFSET_WIDTH-1:0];
            lu_wr_data_d[p] = i_mhq_lookup_data[p];
            lu_addr_d[p]    = lu_line[p];

            // Descending scans so the lowest matching index is the last one written
            ex_hit[p] = 1'b0;
            ex_tag[p] = '0;
            for (int q = LU_PORTS-1; q >= 0; q--) begin
                if ((i_mhq_ex_bypass_en[q] | (i_mhq_ex_bypass_we[q] & i_mhq_ex_bypass_match[q])) &&
                    (i_mhq_ex_bypass_addr[q] == lu_line[p])) begin
                    ex_hit[p] = 1'b1;
                    ex_tag[p] = i_mhq_ex_bypass_tag[q];
                end
            end

            q_hit[p] = 1'b0;
            q_tag[p] = '0;
            for (int e = OPTN_MHQ_DEPTH-1; e >= 0; e--) begin
                if (i_mhq_entry_valid[e] && (i_mhq_entry_addr[e] == lu_line[p])) begin
                    q_hit[p] = 1'b1;
                    q_tag[p] = MHQ_IDX_WIDTH'(e);
                end
            end

            case (i_mhq_lookup_lsu_func[p])
                LSU_FUNC_SB: bs_mask[p] = WORD_SIZE'(1);
                LSU_FUNC_SH: bs_mask[p] = WORD_SIZE'(3);
                LSU_FUNC_SW: bs_mask[p] = WORD_SIZE'(15);
                default:     bs_mask[p] = '0;
            endcase
            lu_byte_select_d[p] = bs_mask[p] << i_mhq_lookup_addr[p][BS_SHIFT_WIDTH-1:0];
        end
    end

    // Sequential priority walk: each port sees the allocations of all lower ports
    always_comb begin
        alloc_k = '0;
        for (int p = 0; p < LU_PORTS; p++) begin
            alloc[p]     = 1'b0;
            alloc_tag[p] = '0;
            port_hit[p]  = 1'b0;
            port_tag[p]  = '0;
            for (int j = 0; j < p; j++) begin
                if (!port_hit[p] && alloc[j] && (lu_line[j] == lu_line[p])) begin
                    port_hit[p] = 1'b1;
                    port_tag[p] = alloc_tag[j];
                end
            end

`ifdef PCYN_MHQ_LU_COALESCE_EN
            conflict[p]  = 1'b0;
            merge_hit[p] = ex_hit[p] | q_hit[p] | port_hit[p];
`else
            conflict[p]  = port_hit[p];
            merge_hit[p] = ex_hit[p] | q_hit[p];
`endif
            if (ex_hit[p])     merge_tag[p] = ex_tag[p];
            else if (q_hit[p]) merge_tag[p] = q_tag[p];
            else               merge_tag[p] = port_tag[p];

            lu_match_d[p] = i_mhq_lookup_valid[p] & merge_hit[p];
            lu_retry_d[p] = i_mhq_lookup_valid[p] & i_ccu_done & (i_ccu_addr == i_mhq_lookup_addr[p]);
            lu_tag_d[p]   = lu_match_d[p] ? merge_tag[p] : '0;

            if (i_mhq_lookup_valid[p] && !i_mhq_lookup_dc_hit[p] && !lu_fill[p] &&
                !lu_match_d[p] && !lu_retry_d[p]) begin
                if (conflict[p] || (free <= (MHQ_IDX_WIDTH+1)'(alloc_k))) begin
                    lu_retry_d[p] = 1'b1;
                end else begin
                    alloc[p]     = 1'b1;
                    alloc_tag[p] = i_mhq_tail_next[MHQ_IDX_WIDTH-1:0] + MHQ_IDX_WIDTH'(alloc_k);
                    lu_tag_d[p]  = alloc_tag[p];
                    alloc_k      = alloc_k + CNT_WIDTH'(1);
                end
            end

            lu_en_d[p] = i_mhq_lookup_valid[p] & ~i_mhq_lookup_dc_hit[p] & ~lu_fill[p] & ~lu_retry_d[p];
        end
        alloc_cnt_d = alloc_k;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lu_en_q          <= '{default: '0};
            lu_we_q          <= '{default: '0};
            lu_match_q       <= '{default: '0};
            lu_retry_q       <= '{default: '0};
            lu_offset_q      <= '{default: '0};
            lu_wr_data_q     <= '{default: '0};
            lu_byte_select_q <= '{default: '0};
            lu_tag_q         <= '{default: '0};
            lu_addr_q        <= '{default: '0};
            alloc_cnt_q      <= '0;
        end else begin
            lu_en_q          <= lu_en_d;
            lu_we_q          <= lu_we_d;
            lu_match_q       <= lu_match_d;
            lu_retry_q       <= lu_retry_d;
            lu_offset_q      <= lu_offset_d;
            lu_wr_data_q     <= lu_wr_data_d;
            lu_byte_select_q <= lu_byte_select_d;
            lu_tag_q         <= lu_tag_d;
            lu_addr_q        <= lu_addr_d;
            alloc_cnt_q      <= alloc_cnt_d;
        end
    end

    assign o_mhq_lu_en          = lu_en_q;
    assign o_mhq_lu_we          = lu_we_q;
    assign o_mhq_lu_match       = lu_match_q;
    assign o_mhq_lu_retry       = lu_retry_q;
    assign o_mhq_lu_offset      = lu_offset_q;
    assign o_mhq_lu_wr_data     = lu_wr_data_q;
    assign o_mhq_lu_byte_select = lu_byte_select_q;
    assign o_mhq_lu_tag         = lu_tag_q;
    assign o_mhq_lu_addr        = lu_addr_q;
    assign o_mhq_lu_alloc_cnt   = alloc_cnt_q;

endmodule

// File: tb/tb_procyon_mhq_lu_mp.sv
// Self-checking bench for procyon_mhq_lu_mp: directed scenarios plus randomized lookups vs. a reference model.
module tb_procyon_mhq_lu_mp;
    localparam int DW = 32, AW = 32, DEPTH = 8, LINE = 32, P = 2, FW = 4;
    localparam int IDX = 3, OFF = 5, WS = 4, LA = 27, CW = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic [IDX:0] tail, head;
    logic ev [DEPTH];
    logic [LA-1:0] eaddr [DEPTH];
    logic xen [P], xwe [P], xmatch [P];
    logic [LA-1:0] xaddr [P];
    logic [IDX-1:0] xtag [P];
    logic lv [P], ldc [P], lwe [P];
    logic [AW-1:0] laddr [P];
    logic [FW-1:0] lfunc [P];
    logic [DW-1:0] ldata [P];
    logic ccu_done;
    logic [AW-1:0] ccu_addr;

    logic o_en [P], o_we [P], o_match [P], o_retry [P];
    logic [OFF-1:0] o_offset [P];
    logic [DW-1:0] o_wdata [P];
    logic [WS-1:0] o_bs [P];
    logic [IDX-1:0] o_tag [P];
    logic [LA-1:0] o_addr [P];
    logic [CW-1:0] o_cnt;

    logic e_en [P], e_we [P], e_match [P], e_retry [P];
    logic [OFF-1:0] e_offset [P];
    logic [DW-1:0] e_wdata [P];
    logic [WS-1:0] e_bs [P];
    logic [IDX-1:0] e_tag [P];
    logic [LA-1:0] e_addr [P];
    logic [CW-1:0] e_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    procyon_mhq_lu_mp dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_mhq_tail_next       (tail),
        .i_mhq_head_next       (head),
        .i_mhq_entry_valid     (ev),
        .i_mhq_entry_addr      (eaddr),
        .i_mhq_ex_bypass_en    (xen),
        .i_mhq_ex_bypass_we    (xwe),
        .i_mhq_ex_bypass_match (xmatch),
        .i_mhq_ex_bypass_addr  (xaddr),
        .i_mhq_ex_bypass_tag   (xtag),
        .i_mhq_lookup_valid    (lv),
        .i_mhq_lookup_dc_hit   (ldc),
        .i_mhq_lookup_we       (lwe),
        .i_mhq_lookup_addr     (laddr),
        .i_mhq_lookup_lsu_func (lfunc),
        .i_mhq_lookup_data     (ldata),
        .i_ccu_done            (ccu_done),
        .i_ccu_addr            (ccu_addr),
        .o_mhq_lu_en           (o_en),
        .o_mhq_lu_we           (o_we),
        .o_mhq_lu_match        (o_match),
        .o_mhq_lu_retry        (o_retry),
        .o_mhq_lu_offset       (o_offset),
        .o_mhq_lu_wr_data      (o_wdata),
        .o_mhq_lu_byte_select  (o_bs),
        .o_mhq_lu_tag          (o_tag),
        .o_mhq_lu_addr         (o_addr),
        .o_mhq_lu_alloc_cnt    (o_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tail = '0; head = '0; ccu_done = 1'b0; ccu_addr = '0;
        for (int e = 0; e < DEPTH; e++) begin ev[e] = 1'b0; eaddr[e] = '0; end
        for (int p = 0; p < P; p++) begin
            xen[p] = 1'b0; xwe[p] = 1'b0; xmatch[p] = 1'b0; xaddr[p] = '0; xtag[p] = '0;
            lv[p] = 1'b0; ldc[p] = 1'b0; lwe[p] = 1'b0; laddr[p] = '0; lfunc[p] = 4'd2;
            ldata[p] = 32'hA5A5_0000 + p;
        end
    endtask

    function automatic logic any_out_set();
        logic r = 1'b0;
        for (int p = 0; p < P; p++)
            r = r | (|{o_en[p], o_we[p], o_match[p], o_retry[p], o_offset[p], o_wdata[p], o_bs[p], o_tag[p], o_addr[p]});
        r = r | (|o_cnt);
        return r;
    endfunction

    // Reference: walk ports oldest-first, tracking free slots and this cycle's new lines
    task automatic model();
        int occ, freec, k, mtag, pidx, lmask;
        bit found, conflict;
        logic [LA-1:0] line;
        logic [LA-1:0] al_line[$];
        int al_tag[$];
        occ = (int'(tail) - int'(head) + 2*DEPTH) % (2*DEPTH);
        freec = DEPTH - occ;
        k = 0;
        for (int p = 0; p < P; p++) begin
            line = laddr[p][AW-1:OFF];
            found = 0; mtag = 0; conflict = 0;
            for (int q = 0; q < P; q++)
                if (!found && (xen[q] || (xwe[q] && xmatch[q])) && xaddr[q] == line) begin found = 1; mtag = int'(xtag[q]); end
            for (int e = 0; e < DEPTH; e++)
                if (!found && ev[e] && eaddr[e] == line) begin found = 1; mtag = e; end
            pidx = -1;
            for (int i = 0; i < al_line.size(); i++)
                if (pidx < 0 && al_line[i] == line) pidx = i;
            if (!found && pidx >= 0) begin
`ifdef PCYN_MHQ_LU_COALESCE_EN
                found = 1; mtag = al_tag[pidx];
`else
                conflict = 1;
`endif
            end
            e_match[p] = lv[p] && found;
            e_retry[p] = lv[p] && ccu_done && (ccu_addr == laddr[p]);
            e_tag[p]   = e_match[p] ? IDX'(mtag) : '0;
            if (lv[p] && !ldc[p] && lfunc[p] != 4'd8 && !e_match[p] && !e_retry[p]) begin
                if (conflict || freec <= k) e_retry[p] = 1'b1;
                else begin
                    e_tag[p] = IDX'((int'(tail) + k) % DEPTH);
                    al_line.push_back(line);
                    al_tag.push_back(int'(e_tag[p]));
                    k++;
                end
            end
            e_en[p]     = lv[p] && !ldc[p] && lfunc[p] != 4'd8 && !e_retry[p];
            e_we[p]     = lwe[p];
            e_offset[p] = laddr[p][OFF-1:0];
            e_addr[p]   = line;
            e_wdata[p]  = ldata[p];
            case (lfunc[p])
                4'd5:    lmask = 1;
                4'd6:    lmask = 3;
                4'd7:    lmask = 15;
                default: lmask = 0;
            endcase
            e_bs[p] = WS'((lmask << laddr[p][1:0]) & 15);
        end
        e_cnt = CW'(k);
    endtask

    task automatic test_reset();
        clear_inputs();
        lv[0] = 1'b1; laddr[0] = 32'h1000; lfunc[0] = 4'd7; lwe[0] = 1'b1;
        n_rst = 1'b0;
        repeat (3) step();
        checks++;
        if (any_out_set() !== 1'b0) begin errors++; $display("FAIL reset_outputs: got nonzero outputs, required all zero"); end
        n_rst = 1'b1;
        step();
        checks++;
        if ({o_en[0], o_tag[0], o_bs[0], o_cnt} !== {1'b1, 3'd0, 4'b1111, 2'd1})
            begin errors++; $display("FAIL reset_first_out: got en=%b tag=%0d bs=%b cnt=%0d required en=1 tag=0 bs=1111 cnt=1", o_en[0], o_tag[0], o_bs[0], o_cnt); end
    endtask

    task automatic test_alloc_basic();
        clear_inputs();
        tail = 4'd3; head = 4'd3;
        lv[0] = 1'b1; laddr[0] = 32'h1000;
        lv[1] = 1'b1; laddr[1] = 32'h2000;
        step();
        checks++;
        if ({o_tag[0], o_tag[1], o_match[0], o_match[1], o_en[0], o_en[1], o_cnt} !== {3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2})
            begin errors++; $display("FAIL alloc_basic: got tag=%0d/%0d match=%b/%b en=%b/%b cnt=%0d required 3/4 0/0 1/1 2", o_tag[0], o_tag[1], o_match[0], o_match[1], o_en[0], o_en[1], o_cnt); end
    endtask

    task automatic test_nearly_full();
        clear_inputs();
        tail = 4'd6; head = 4'd15;
        lv[0] = 1'b1; laddr[0] = 32'h1000;
        lv[1] = 1'b1; laddr[1] = 32'h2000;
        step();
        checks++;
        if ({o_tag[0], o_en[0], o_retry[0], o_retry[1], o_en[1], o_cnt} !== {3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1})
            begin errors++; $display("FAIL occ7: got tag0=%0d en=%b/%b retry=%b/%b cnt=%0d required 6 en=1/0 retry=0/1 cnt=1", o_tag[0], o_en[0], o_en[1], o_retry[0], o_retry[1], o_cnt); end
    endtask

    task automatic test_full();
        clear_inputs();
        head = 4'd0; tail = 4'd8;
        ev[3] = 1'b1; eaddr[3] = 27'h80;
        lv[0] = 1'b1; laddr[0] = 32'h5000;
        lv[1] = 1'b1; laddr[1] = 32'h1010;
        step();
        checks++;
        if ({o_retry[0], o_en[0], o_match[1], o_en[1], o_tag[1], o_cnt} !== {1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 2'd0})
            begin errors++; $display("FAIL full: got retry0=%b en0=%b match1=%b en1=%b tag1=%0d cnt=%0d required 1 0 1 1 3 0", o_retry[0], o_en[0], o_match[1], o_en[1], o_tag[1], o_cnt); end
    endtask

    task automatic test_merge_entry();
        clear_inputs();
        ev[5] = 1'b1; eaddr[5] = 27'h80;
        lv[0] = 1'b1; lwe[0] = 1'b1; lfunc[0] = 4'd6; laddr[0] = 32'h1002; ldata[0] = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({o_match[0], o_en[0], o_tag[0], o_bs[0], o_cnt, o_offset[0]} !== {1'b1, 1'b1, 3'd5, 4'b1100, 2'd0, 5'd2})
            begin errors++; $display("FAIL merge_entry: got match=%b en=%b tag=%0d bs=%b cnt=%0d off=%0d required 1 1 5 1100 0 2", o_match[0], o_en[0], o_tag[0], o_bs[0], o_cnt, o_offset[0]); end
        checks++;
        if ({o_we[0], o_wdata[0], o_addr[0]} !== {1'b1, 32'hDEAD_BEEF, 27'h80})
            begin errors++; $display("FAIL merge_fields: got we=%b data=%h addr=%h required 1 deadbeef 80", o_we[0], o_wdata[0], o_addr[0]); end
    endtask

    task automatic test_same_line();
        clear_inputs();
        tail = 4'd2; head = 4'd2;
        lv[0] = 1'b1; laddr[0] = 32'h3000;
        lv[1] = 1'b1; laddr[1] = 32'h3004;
        step();
        checks++;
`ifdef PCYN_MHQ_LU_COALESCE_EN
        if ({o_tag[0], o_tag[1], o_match[1], o_en[1], o_cnt} !== {3'd2, 3'd2, 1'b1, 1'b1, 2'd1})
            begin errors++; $display("FAIL same_line_miss: got tag=%0d/%0d match1=%b en1=%b cnt=%0d required 2/2 1 1 1", o_tag[0], o_tag[1], o_match[1], o_en[1], o_cnt); end
`else
        if ({o_tag[0], o_en[0], o_retry[1], o_en[1], o_cnt} !== {3'd2, 1'b1, 1'b1, 1'b0, 2'd1})
            begin errors++; $display("FAIL same_line_miss: got tag0=%0d en0=%b retry1=%b en1=%b cnt=%0d required 2 1 1 0 1", o_tag[0], o_en[0], o_retry[1], o_en[1], o_cnt); end
`endif
        ev[1] = 1'b1; eaddr[1] = 27'h180;
        step();
        checks++;
        if ({o_tag[0], o_tag[1], o_match[0], o_match[1], o_cnt} !== {3'd1, 3'd1, 1'b1, 1'b1, 2'd0})
            begin errors++; $display("FAIL same_line_qhit: got tag=%0d/%0d match=%b/%b cnt=%0d required 1/1 1/1 0", o_tag[0], o_tag[1], o_match[0], o_match[1], o_cnt); end
    endtask

    task automatic test_tag_wrap();
        clear_inputs();
        tail = 4'd7; head = 4'd7;
        lv[0] = 1'b1; laddr[0] = 32'h1000;
        lv[1] = 1'b1; laddr[1] = 32'h2000;
        step();
        checks++;
        if ({o_tag[0], o_tag[1], o_cnt} !== {3'd7, 3'd0, 2'd2})
            begin errors++; $display("FAIL tag_wrap: got tag=%0d/%0d cnt=%0d required 7/0 2", o_tag[0], o_tag[1], o_cnt); end
    endtask

    task automatic test_ccu_retry();
        clear_inputs();
        lv[0] = 1'b1; laddr[0] = 32'h4000;
        ccu_done = 1'b1; ccu_addr = 32'h4000;
        step();
        checks++;
        if ({o_retry[0], o_en[0], o_cnt} !== {1'b1, 1'b0, 2'd0})
            begin errors++; $display("FAIL ccu_retry: got retry=%b en=%b cnt=%0d required 1 0 0", o_retry[0], o_en[0], o_cnt); end
        ccu_done = 1'b0;
        step();
        checks++;
        if ({o_retry[0], o_en[0], o_cnt} !== {1'b0, 1'b1, 2'd1})
            begin errors++; $display("FAIL ccu_replay: got retry=%b en=%b cnt=%0d required 0 1 1", o_retry[0], o_en[0], o_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            head = IDX'(0) + 4'($urandom_range(0, 15));
            tail = head + 4'($urandom_range(0, DEPTH));
            for (int e = 0; e < DEPTH; e++) begin
                ev[e] = ($urandom_range(0, 2) == 0);
                eaddr[e] = LA'(32'h80 + $urandom_range(0, 7));
            end
            for (int q = 0; q < P; q++) begin
                xen[q] = ($urandom_range(0, 5) == 0);
                xwe[q] = 1'($urandom_range(0, 1));
                xmatch[q] = ($urandom_range(0, 3) == 0);
                xaddr[q] = LA'(32'h80 + $urandom_range(0, 7));
                xtag[q] = IDX'($urandom_range(0, 7));
            end
            for (int p = 0; p < P; p++) begin
                lv[p] = ($urandom_range(0, 3) != 0);
                ldc[p] = ($urandom_range(0, 3) == 0);
                lwe[p] = 1'($urandom_range(0, 1));
                laddr[p] = ((32'h80 + $urandom_range(0, 7)) << 5) | $urandom_range(0, 31);
                lfunc[p] = FW'($urandom_range(0, 8));
                ldata[p] = $urandom;
            end
            ccu_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) ccu_addr = laddr[$urandom_range(0, P-1)];
            else ccu_addr = ((32'h80 + $urandom_range(0, 7)) << 5) | $urandom_range(0, 31);
            model();
            step();
            for (int p = 0; p < P; p++) begin
                checks++;
                if ({o_en[p], o_we[p], o_match[p], o_retry[p], o_tag[p], o_offset[p], o_bs[p], o_addr[p], o_wdata[p]} !==
                    {e_en[p], e_we[p], e_match[p], e_retry[p], e_tag[p], e_offset[p], e_bs[p], e_addr[p], e_wdata[p]}) begin
                    errors++;
                    $display("FAIL rand_port%0d it%0d: got en=%b we=%b match=%b retry=%b tag=%0d off=%0d bs=%b addr=%h data=%h required en=%b we=%b match=%b retry=%b tag=%0d off=%0d bs=%b addr=%h data=%h",
                             p, it, o_en[p], o_we[p], o_match[p], o_retry[p], o_tag[p], o_offset[p], o_bs[p], o_addr[p], o_wdata[p],
                             e_en[p], e_we[p], e_match[p], e_retry[p], e_tag[p], e_offset[p], e_bs[p], e_addr[p], e_wdata[p]);
                end
            end
            checks++;
            if (o_cnt !== e_cnt) begin errors++; $display("FAIL rand_cnt it%0d: got %0d required %0d", it, o_cnt, e_cnt); end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        lv[0] = 1'b1; laddr[0] = 32'h1000; lfunc[0] = 4'd5;
        step();
        checks++;
        if (o_en[0] !== 1'b1) begin errors++; $display("FAIL async_pre: got en=%b required 1", o_en[0]); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (any_out_set() !== 1'b0) begin errors++; $display("FAIL async_reset: got nonzero outputs, required all zero"); end
        laddr[0] = 32'h2000; tail = 4'd5; head = 4'd5;
        #2 n_rst = 1'b1;
        step();
        checks++;
        if ({o_en[0], o_tag[0], o_addr[0], o_cnt} !== {1'b1, 3'd5, 27'h100, 2'd1})
            begin errors++; $display("FAIL async_release: got en=%b tag=%0d addr=%h cnt=%0d required 1 5 100 1", o_en[0], o_tag[0], o_addr[0], o_cnt); end
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_nearly_full();
        test_full();
        test_merge_entry();
        test_same_line();
        test_tag_wrap();
        test_ccu_retry();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/procyon_mhq_lu_mp.md
# procyon_mhq_lu_mp

Multi-port miss handling queue (MHQ) lookup stage. It accepts up to OPTN_MHQ_LU_PORTS load/store lookups per cycle from the LSU and checks each one against valid MHQ entries, the EX-stage bypass and lower-numbered ports in the same cycle. For each port it decides whether to merge into an existing entry, allocate a new entry at tail+k, or retry. It registers per-port results, a byte-lane mask and an allocation count for the MHQ EX stage.

## Interface
- OPTN_DATA_WIDTH, 32, data word width
- OPTN_ADDR_WIDTH, 32, address width
- OPTN_MHQ_DEPTH, 8, MHQ entries; power of two
- OPTN_DC_LINE_SIZE, 32, line bytes
- OPTN_MHQ_LU_PORTS, 2, lookup ports; port 0 is oldest and has highest priority
- Derived: MHQ_IDX_WIDTH = clog2(DEPTH); DC_OFFSET_WIDTH = clog2(LINE_SIZE); WORD_SIZE = DATA_WIDTH/8; LA = ADDR_WIDTH-DC_OFFSET_WIDTH (line-address width)
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_mhq_tail_next, i_mhq_head_next  in  MHQ_IDX_WIDTH+1 each  next-cycle pointers; MSB is the wrap bit
- i_mhq_entry_valid[DEPTH]  in  1  entry valid
- i_mhq_entry_addr[DEPTH]  in  LA  entry line address
- i_mhq_ex_bypass_en[P], i_mhq_ex_bypass_we[P], i_mhq_ex_bypass_match[P]  in  1  EX-stage per-port status
- i_mhq_ex_bypass_addr[P]  in  LA  EX-stage line address
- i_mhq_ex_bypass_tag[P]  in  MHQ_IDX_WIDTH  EX-stage tag
- i_mhq_lookup_valid[P], i_mhq_lookup_dc_hit[P], i_mhq_lookup_we[P]  in  1  per-port request
- i_mhq_lookup_addr[P]  in  ADDR_WIDTH  byte address
- i_mhq_lookup_lsu_func[P]  in  PCYN_LSU_FUNC_WIDTH  LSU op
- i_mhq_lookup_data[P]  in  DATA_WIDTH  store data
- i_ccu_done  in  1  CCU fill completing
- i_ccu_addr  in  ADDR_WIDTH  fill address
- o_mhq_lu_en[P], o_mhq_lu_we[P], o_mhq_lu_match[P], o_mhq_lu_retry[P]  out  1  per-port result
- o_mhq_lu_offset[P]  out  DC_OFFSET_WIDTH  line offset
- o_mhq_lu_wr_data[P]  out  DATA_WIDTH  store data
- o_mhq_lu_byte_select[P]  out  WORD_SIZE  aligned byte mask
- o_mhq_lu_tag[P]  out  MHQ_IDX_WIDTH  MHQ entry tag
- o_mhq_lu_addr[P]  out  LA  line address
- o_mhq_lu_alloc_cnt  out  clog2(P+1)  new entries allocated this cycle

## Operation
- occ = (tail_next − head_next) mod 2^(IDX+1); free = DEPTH − occ.
- Ports are evaluated in order p = 0..P−1. Per port p:
  - ex_hit: for any port q, ex_bypass_en[q] | (ex_bypass_we[q] & ex_bypass_match[q]), and ex_bypass_addr[q] equals the line address. The lowest q wins.
  - q_hit: a valid entry has an equal line address. The lowest index wins.
  - port_hit: a lower port p′ that allocated this cycle with the same line address. Applies only with coalescing enabled (see Configuration).
- Merge-tag priority: ex_hit, then q_hit, then port_hit. match = valid & (any hit).
- If valid & ~dc_hit & ~FILL & ~match, the port needs a new entry.
  - It allocates if free > k, where k = allocations made by lower ports this cycle.
  - The new tag is (tail_next + k) mod DEPTH; k then increments.
  - Otherwise retry = 1.
- retry is also forced when i_ccu_done & (i_ccu_addr == lookup_addr), regardless of match.
- A retried port does not consume a slot.
- en = valid & ~dc_hit & ~FILL & ~retry.
- Byte select: SB=1, SH=3, SW=15, else 0. The mask is shifted left by addr[clog2(WORD_SIZE)-1:0] and truncated to WORD_SIZE.
- alloc_cnt = final k.

## Timing
- All outputs are registered; latency is 1 cycle from lookup inputs to outputs.
- There is no backpressure. The upstream re-presents retried requests.
- Reset is asynchronous. While n_rst=0, every output is 0, including tag, byte_select, data and alloc_cnt.
- The first valid outputs appear one cycle after the first clk edge with n_rst=1.
- A reset asserted mid-operation clears in-flight outputs immediately, with no clock required.
- Boundary conditions:
  - occ=DEPTH: every non-matching miss retries; matches still enable.
  - Tags wrap modulo DEPTH; tail=7 with two allocations gives tags 7 and 0.
  - Two ports with the same line address and a q_hit both merge to the same tag; alloc_cnt=0.

## Configuration
- PCYN_MHQ_LU_COALESCE_EN:
  - Defined: same-cycle same-line misses on higher ports merge (match=1) into the lower port's newly allocated tag.
  - Undefined: a higher port whose line equals a lower port's same-cycle allocation gets retry=1 and en=0, and allocates nothing.

## Test plan
- P=2, DEPTH=8, empty queue, tail=3; port0 miss 0x1000, port1 miss 0x2000 -> tags 3 and 4, match=0/0, en=1/1, alloc_cnt=2.
- occ=7, tail=6; two misses to different lines -> port0 tag 6, en=1; port1 retry=1, en=0; alloc_cnt=1.
- Entry 5 valid at line 0x1000; port0 SH store to 0x1002 -> match=1, tag=5, byte_select=0b1100, alloc_cnt=0.
- Port0 and port1 both miss line 0x3000 -> coalesce defined: both tag=tail, port1 match=1, alloc_cnt=1; undefined: port1 retry=1.
- i_ccu_done with i_ccu_addr=0x4000 and port0 lookup 0x4000 -> retry=1, en=0; the same request next cycle without ccu_done -> en=1.
- Assert n_rst=0 between clock edges while outputs are valid -> all outputs 0 immediately; release -> outputs follow the new inputs after one edge.
